// File: rtl/pipe_mem_if.sv
// Data-bus channel between the memory stage (master) and the data memory (slave).
interface pipe_mem_if #(
    parameter int XLEN = 64
);
    logic            dbus_req;
    logic            dbus_we;
    logic [XLEN-1:0] dbus_addr;
    logic [XLEN-1:0] dbus_wdata;
    logic [7:0]      dbus_wstrb;
    logic            dbus_addr_ok;
    logic            dbus_data_ok;
    logic [XLEN-1:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        input  dbus_addr_ok, dbus_data_ok, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        output dbus_addr_ok, dbus_data_ok, dbus_rdata
    );
endinterface

// File: rtl/pipe_mem.sv
// Memory stage: one outstanding data-bus access with stall, flush/drain handling
// and per-lane writeback merge of the extended load result.
module pipe_mem #(
    parameter int XLEN      = 64,
    parameter int ISSUE_NUM = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic                           flush,
    input  logic                           mem_ena,
    input  logic                           mem_write,
    input  logic [2:0]                     mem_funct3,
    input  logic [XLEN-1:0]                mem_addr,
    input  logic [XLEN-1:0]                mem_wdata,
    input  logic                           mem_lane,
    input  logic [ISSUE_NUM-1:0]           ex_rd_en,
    input  logic [ISSUE_NUM-1:0][4:0]      ex_rd,
    input  logic [ISSUE_NUM-1:0][XLEN-1:0] ex_res,
    pipe_mem_if.master                     bus,
    output logic                           mem_stall,
    output logic                           mem_misalign,
    output logic [ISSUE_NUM-1:0]           mem_rd_en,
    output logic [ISSUE_NUM-1:0][4:0]      mem_rd,
    output logic [ISSUE_NUM-1:0][XLEN-1:0] mem_res
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

    state_t          state;
    logic [2:0]      r_off;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] load_res;
    logic [7:0]      size_mask;
    logic            addr_bad;
    logic            misalign;
    logic            start;

    always_comb begin
        size_mask = 8'h01;
        addr_bad  = 1'b0;
        case (mem_funct3[1:0])
            2'b00:   begin size_mask = 8'h01; addr_bad = 1'b0;           end
            2'b01:   begin size_mask = 8'h03; addr_bad = mem_addr[0];    end
            2'b10:   begin size_mask = 8'h0f; addr_bad = |mem_addr[1:0]; end
            default: begin size_mask = 8'hff; addr_bad = |mem_addr[2:0]; end
        endcase
    end

    assign misalign     = in_valid && mem_ena && addr_bad;
    assign mem_misalign = misalign;
    assign start        = in_valid && mem_ena && !flush && !misalign;
    assign mem_stall    = rst_n && ((state == DRAIN) ||
                          (in_valid && mem_ena && !misalign && state != DONE));

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                               input logic [2:0] off,
                                               input logic [2:0] f3);
        logic [XLEN-1:0] sh;
        sh = raw >> {off, 3'b000};
        case (f3)
            3'b000:  return {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b001:  return {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b010:  return {{(XLEN-32){sh[31]}}, sh[31:0]};
            3'b100:  return {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, sh[15:0]};
            3'b110:  return {{(XLEN-32){1'b0}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    // A flush that coincides with the response needs no drain: nothing is left in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.dbus_req   <= 1'b0;
            bus.dbus_we    <= 1'b0;
            bus.dbus_addr  <= '0;
            bus.dbus_wdata <= '0;
            bus.dbus_wstrb <= '0;
            r_off          <= '0;
            r_funct3       <= '0;
            load_res       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state          <= REQ;
                    bus.dbus_req   <= 1'b1;
                    bus.dbus_we    <= mem_write;
                    bus.dbus_addr  <= {mem_addr[XLEN-1:3], 3'b000};
                    bus.dbus_wdata <= mem_wdata << {mem_addr[2:0], 3'b000};
                    bus.dbus_wstrb <= mem_write ? size_mask << mem_addr[2:0] : '0;
                    r_off          <= mem_addr[2:0];
                    r_funct3       <= mem_funct3;
                end
                REQ: begin
                    if (flush) begin
                        bus.dbus_req <= 1'b0;
                        state <= (bus.dbus_addr_ok && !bus.dbus_data_ok) ? DRAIN : IDLE;
                    end else if (bus.dbus_addr_ok) begin
                        bus.dbus_req <= 1'b0;
                        if (bus.dbus_data_ok) begin
                            state <= DONE;
                            if (!bus.dbus_we) load_res <= extend(bus.dbus_rdata, r_off, r_funct3);
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state <= bus.dbus_data_ok ? IDLE : DRAIN;
                    end else if (bus.dbus_data_ok) begin
                        state <= DONE;
                        if (!bus.dbus_we) load_res <= extend(bus.dbus_rdata, r_off, r_funct3);
                    end
                end
                DONE:    state <= IDLE;
                DRAIN:   if (bus.dbus_data_ok) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_rd_en = '0;
        mem_rd    = '0;
        mem_res   = '0;
        if (in_valid && !flush) begin
            mem_rd_en = ex_rd_en;
            mem_rd    = ex_rd;
            mem_res   = ex_res;
            for (int unsigned i = 0; i < ISSUE_NUM; i++) begin
                if (i == 32'(mem_lane)) begin
                    if (misalign) mem_rd_en[i] = 1'b0;
                    else if (state == DONE && mem_ena && !mem_write) mem_res[i] = load_res;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipe_mem.sv
// Randomized bench for pipe_mem: bus slave responder plus a byte-level reference
// model for strobes, store alignment, load extension and stall latency.
module tb_pipe_mem;
    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            flush;
    logic            mem_ena;
    logic            mem_write;
    logic [2:0]      mem_funct3;
    logic [63:0]     mem_addr;
    logic [63:0]     mem_wdata;
    logic            mem_lane;
    logic [1:0]      ex_rd_en;
    logic [1:0][4:0] ex_rd;
    logic [1:0][63:0] ex_res;
    logic            mem_stall;
    logic            mem_misalign;
    logic [1:0]      mem_rd_en;
    logic [1:0][4:0] mem_rd;
    logic [1:0][63:0] mem_res;

    int n_checks = 0;
    int n_errors = 0;

    pipe_mem_if #(.XLEN(64)) bus ();

    pipe_mem #(.XLEN(64), .ISSUE_NUM(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .flush        (flush),
        .mem_ena      (mem_ena),
        .mem_write    (mem_write),
        .mem_funct3   (mem_funct3),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_lane     (mem_lane),
        .ex_rd_en     (ex_rd_en),
        .ex_rd        (ex_rd),
        .ex_res       (ex_res),
        .bus          (bus),
        .mem_stall    (mem_stall),
        .mem_misalign (mem_misalign),
        .mem_rd_en    (mem_rd_en),
        .mem_rd       (mem_rd),
        .mem_res      (mem_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        bus.dbus_addr_ok = 1'b0;
        bus.dbus_data_ok = 1'b0;
    endtask

    task automatic drive(input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input int lane);
        in_valid   = 1'b1;
        mem_ena    = 1'b1;
        flush      = 1'b0;
        mem_write  = w;
        mem_funct3 = f3;
        mem_addr   = a;
        mem_wdata  = wd;
        mem_lane   = lane[0];
        ex_rd_en   = 2'($urandom);
        ex_rd[0]   = 5'($urandom);
        ex_rd[1]   = 5'($urandom);
        ex_res[0]  = {$urandom, $urandom};
        ex_res[1]  = {$urandom, $urandom};
    endtask

    task automatic run_txn(input logic w, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input logic [63:0] rd,
                           input int ao_dly, input int do_dly, input int lane_in);
        int size, off, lane, cyc, req_cnt, acc_at;
        bit mis, any_req, done;
        logic [63:0] val, exp_res, exp_wd;
        logic [7:0]  exp_strb;
        logic [7:0]  rb [8];

        size = 1 << f3[1:0];
        off  = int'(a[2:0]);
        mis  = (a % 64'(size)) != 0;
        lane = (lane_in < 0) ? int'($urandom_range(0, 1)) : lane_in;
        for (int i = 0; i < 8; i++) rb[i] = rd[8*i +: 8];
        val = '0;
        if (!mis) begin
            for (int i = 0; i < size; i++) val |= 64'(rb[off+i]) << (8*i);
            if (!f3[2] && size < 8 && rb[off+size-1][7]) val |= ~64'd0 << (8*size);
        end
        exp_strb = w ? 8'(((1 << size) - 1) << off) : 8'h00;
        exp_wd   = wd << (8*off);

        tick();
        drive(w, f3, a, wd, lane);
        if (mis) ex_rd_en[lane] = 1'b1;
        bus.dbus_rdata = rd;
        exp_res = w ? ex_res[lane] : val;
        #1;
        check("misalign", mem_misalign, mis);
        if (mis) begin
            check("mis_stall", mem_stall, 0);
            check("mis_rd_en", mem_rd_en[lane], 0);
            check("mis_other_en", mem_rd_en[1-lane], ex_rd_en[1-lane]);
            any_req = 0;
            repeat (3) begin
                tick();
                #1;
                any_req |= bus.dbus_req;
            end
            check("mis_no_req", any_req, 0);
        end else begin
            check("stall_c0", mem_stall, 1);
            cyc = 0; req_cnt = 0; acc_at = -1; done = 0;
            while (!done && cyc < 40) begin
                if (!mem_stall) begin
                    done = 1;
                    check("latency", cyc, 2 + ao_dly + do_dly);
                    check("req_count", req_cnt, ao_dly + 1);
                    check("req_in_done", bus.dbus_req, 0);
                    check("res_lane", mem_res[lane], exp_res);
                    check("rd_en", mem_rd_en, ex_rd_en);
                    check("rd_lane", mem_rd[lane], ex_rd[lane]);
                    check("res_other", mem_res[1-lane], ex_res[1-lane]);
                end else begin
                    if (bus.dbus_req) begin
                        if (req_cnt == 0) begin
                            check("bus_addr", bus.dbus_addr, {a[63:3], 3'b000});
                            check("bus_we", bus.dbus_we, w);
                            check("bus_wstrb", bus.dbus_wstrb, exp_strb);
                            if (w) check("bus_wdata", bus.dbus_wdata, exp_wd);
                        end
                        if (req_cnt == ao_dly) begin
                            bus.dbus_addr_ok = 1'b1;
                            acc_at = cyc;
                        end
                        req_cnt++;
                    end
                    if (acc_at >= 0 && cyc == acc_at + do_dly) bus.dbus_data_ok = 1'b1;
                    tick();
                    #1;
                    cyc++;
                end
            end
            check("timeout", done, 1);
        end

        tick();
        drive(1'b0, 3'b000, '0, '0, 0);
        mem_ena = 1'b0;
        #1;
        check("nomem_stall", mem_stall, 0);
        check("nomem_rd_en", mem_rd_en, ex_rd_en);
        check("nomem_res", mem_res[0], ex_res[0]);
        tick();
        in_valid = 1'b0;
        #1;
        check("inval_rd_en", mem_rd_en, 0);
    endtask

    initial begin
        logic        w;
        logic [2:0]  f3;
        logic [63:0] a;

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; mem_ena = 1'b0; mem_write = 1'b0;
        mem_funct3 = '0; mem_addr = '0; mem_wdata = '0; mem_lane = 1'b0;
        ex_rd_en = '0; ex_rd = '0; ex_res = '0;
        bus.dbus_addr_ok = 1'b0; bus.dbus_data_ok = 1'b0; bus.dbus_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", bus.dbus_req, 0);
        check("rst_we", bus.dbus_we, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_misalign", mem_misalign, 0);
        rst_n = 1'b1;

        run_txn(1'b0, 3'b010, 64'h1004, '0, 64'h8000_0001_1234_5678, 0, 2, 0);
        run_txn(1'b1, 3'b000, 64'h1003, 64'hAB, '0, 1, 1, 0);
        run_txn(1'b0, 3'b001, 64'h1001, '0, '0, 0, 0, 0);
        run_txn(1'b0, 3'b100, 64'h2000, '0, 64'h1122_3344_5566_77F0, 0, 0, 1);

        // Flush during WAIT, next bundle must wait for the drained response.
        tick(); drive(1'b0, 3'b011, 64'h3008, '0, 0); #1;
        check("fw_c0_stall", mem_stall, 1);
        tick(); #1;
        check("fw_req", bus.dbus_req, 1);
        bus.dbus_addr_ok = 1'b1;
        tick(); #1;
        check("fw_wait_req", bus.dbus_req, 0);
        flush = 1'b1; #1;
        check("fw_flush_rd_en", mem_rd_en, 0);
        check("fw_flush_stall", mem_stall, 1);
        tick(); drive(1'b0, 3'b010, 64'h4000, '0, 0); bus.dbus_rdata = 64'h0000_0000_7654_3210; #1;
        check("fw_drain1_req", bus.dbus_req, 0);
        check("fw_drain1_stall", mem_stall, 1);
        tick(); #1;
        check("fw_drain2_req", bus.dbus_req, 0);
        check("fw_drain2_stall", mem_stall, 1);
        bus.dbus_data_ok = 1'b1;
        tick(); #1;
        check("fw_idle_req", bus.dbus_req, 0);
        check("fw_idle_stall", mem_stall, 1);
        tick(); #1;
        check("fw_new_req", bus.dbus_req, 1);
        check("fw_new_addr", bus.dbus_addr, 64'h4000);
        bus.dbus_addr_ok = 1'b1; bus.dbus_data_ok = 1'b1;
        tick(); #1;
        check("fw_done_stall", mem_stall, 0);
        check("fw_done_res", mem_res[0], 64'h0000_0000_7654_3210);
        tick(); in_valid = 1'b0;

        // Flush while the request is still unaccepted withdraws it.
        tick(); drive(1'b1, 3'b011, 64'h5000, 64'h55, 0); #1;
        tick(); #1;
        check("fr_req", bus.dbus_req, 1);
        flush = 1'b1;
        tick(); flush = 1'b0; in_valid = 1'b0; #1;
        check("fr_withdrawn", bus.dbus_req, 0);
        check("fr_stall", mem_stall, 0);
        tick(); #1;
        check("fr_still_idle", bus.dbus_req, 0);

        // Reset while waiting abandons the access.
        tick(); drive(1'b0, 3'b011, 64'h6000, '0, 0); bus.dbus_rdata = 64'hDEAD_BEEF_0BAD_F00D; #1;
        tick(); #1;
        check("rw_req", bus.dbus_req, 1);
        bus.dbus_addr_ok = 1'b1;
        tick(); #1;
        check("rw_wait_stall", mem_stall, 1);
        rst_n = 1'b0; #1;
        check("rw_rst_req", bus.dbus_req, 0);
        check("rw_rst_stall", mem_stall, 0);
        tick(); rst_n = 1'b1; #1;
        check("rw_idle_req", bus.dbus_req, 0);
        check("rw_idle_stall", mem_stall, 1);
        tick(); #1;
        check("rw_reissue", bus.dbus_req, 1);
        bus.dbus_addr_ok = 1'b1; bus.dbus_data_ok = 1'b1;
        tick(); #1;
        check("rw_done_stall", mem_stall, 0);
        check("rw_done_res", mem_res[0], 64'hDEAD_BEEF_0BAD_F00D);
        tick(); in_valid = 1'b0;

        for (int t = 0; t < 60; t++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'((1 << f3[1:0]) - 1);
            run_txn(w, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
